thumb_fetch_queue: RTL and testbench
====================================

THUMB_FETCH_QUEUE -- requirements
Module: thumb_fetch_queue

Interface
REQ-001 The block SHALL have parameter FETCH_HW, default 2: halfwords delivered per fetch beat (legal values 1, 2, 4).
REQ-002 The block SHALL have parameter DEPTH, default 8: queue capacity in halfwords (power of 2, at least 2*FETCH_HW).
REQ-003 The block SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 The block SHALL have port in_hw, input, 16*FETCH_HW: fetched halfwords, with lane 0 in bits [15:0] and oldest in program order.
REQ-006 The block SHALL have port in_cnt, input, $clog2(FETCH_HW+1): number of valid lanes, taken from lane 0 upward.
REQ-007 The block SHALL have port in_valid, input, 1: the fetch beat is offered.
REQ-008 The block SHALL have port in_ready, output, 1: the queue can accept a full beat.
REQ-009 The block SHALL have port flush, input, 1: discard all queued halfwords (branch or exception).
REQ-010 The block SHALL have port inst, output, 32: the assembled instruction.
REQ-011 The block SHALL have port inst_is32, output, 1: inst is a 32-bit Thumb-2 encoding.
REQ-012 The block SHALL have port out_valid, output, 1: inst is complete and valid.
REQ-013 The block SHALL have port out_ready, input, 1: the decode stage consumes inst.
REQ-014 The block SHALL have port occupancy, output, $clog2(DEPTH+1): halfwords currently queued.

Function
REQ-015 The queue SHALL be a circular buffer of DEPTH halfwords, with read and write pointers that wrap modulo DEPTH.
REQ-016 in_ready SHALL be 1 exactly when DEPTH - occupancy >= FETCH_HW, evaluated from registered state only; same-cycle pops are not credited.
REQ-017 On in_valid & in_ready & !flush, the queue SHALL write in_cnt halfwords in lane order, and occupancy SHALL increase by in_cnt; in_cnt = 0 is a legal no-op.
REQ-018 in_valid with in_ready = 0 SHALL be ignored, and the source SHALL hold the beat until it is accepted.
REQ-019 The head halfword SHALL be classed as a 32-bit prefix when bits [15:11] equal 5'b11101, 5'b11110 or 5'b11111.
REQ-020 out_valid SHALL be (occupancy >= 1 and head is not a prefix) or (occupancy >= 2).
REQ-021 For a 16-bit instruction, inst SHALL be {16'h0000, head}; for a 32-bit instruction, inst SHALL be {head, head+1}.
REQ-022 inst_is32 SHALL equal the prefix class of the head whenever out_valid = 1.
REQ-023 When out_valid = 0, inst and inst_is32 SHALL be 0.
REQ-024 On out_valid & out_ready & !flush, the queue SHALL pop 1 halfword (16-bit instruction) or 2 halfwords (32-bit instruction).
REQ-025 A push and a pop in the same cycle SHALL both take effect: occupancy_next = occupancy + pushed - popped.
REQ-026 A 32-bit instruction whose halves straddle pointer wrap-around SHALL assemble correctly.
REQ-027 A lone prefix halfword at the head SHALL hold out_valid = 0 until its second halfword arrives.
REQ-028 flush SHALL override push and pop in the same cycle: in the next cycle occupancy = 0, both pointers = 0, and out_valid = 0.
REQ-029 A halfword pushed in cycle N SHALL first be visible at the outputs in cycle N+1; there is no combinational path from in_* to out_*.
REQ-030 outputs SHALL be driven combinationally from registered state, with no additional output register stage.

Reset
REQ-031 While rst = 1 at a clock edge, the block SHALL set read pointer, write pointer and occupancy to 0; storage contents are don't-care.
REQ-032 From the cycle after reset, the outputs SHALL be out_valid = 0, inst = 0, inst_is32 = 0, occupancy = 0, and in_ready = 1.
REQ-033 rst SHALL take priority over flush, push and pop, and SHALL abort any partially assembled instruction.

Structure
REQ-034 A shared package SHALL hold the three 32-bit prefix constants and the halfword type.
REQ-035 One combinational sub-module, thumb_len_dec, SHALL map a halfword to the is32 flag; it is reused by the pre-decode stage.
REQ-036 The storage SHALL be a flop array with no RAM macro.

Verification
REQ-037 With FETCH_HW=2 and DEPTH=8, push in_hw={16'hBF00,16'h4608} with in_cnt=2 -> the bench SHALL see inst=32'h00004608 then 32'h0000BF00, each with inst_is32=0, in consecutive cycles with out_ready=1.
REQ-038 Push {16'hF000,16'hE92D} with in_cnt=1 -> the bench SHALL see out_valid=0 and occupancy=1; then push 16'hF000 -> the bench SHALL see inst=32'hE92DF000 and inst_is32=1 the next cycle.
REQ-039 Fill with out_ready=0 until occupancy=7 -> the bench SHALL see in_ready=0 and an offered beat not accepted; then pop 1 halfword -> the bench SHALL see in_ready=1 the following cycle.
REQ-040 Place a 32-bit instruction with its first half at index 7 and second half at index 0 -> the bench SHALL see inst correct and the read pointer wrap to 1.
REQ-041 Assert flush together with in_valid and out_ready at occupancy=5 -> the bench SHALL see occupancy=0 and out_valid=0 next cycle, with the beat dropped.
REQ-042 Assert rst for one cycle in the middle of a 32-bit assembly -> the bench SHALL see all outputs at their REQ-032 values the next cycle.

Source files
------------

// File: rtl/thumb_fetch_queue_pkg.sv
// Shared Thumb fetch definitions: the halfword type and the leading-bit
// patterns that mark the first half of a 32-bit Thumb-2 instruction.
package thumb_fetch_queue_pkg;

  typedef logic [15:0] halfword_t;

  // Bits [15:11] of a halfword that opens a 32-bit encoding.
  localparam logic [4:0] PREFIX32_A = 5'b11101;
  localparam logic [4:0] PREFIX32_B = 5'b11110;
  localparam logic [4:0] PREFIX32_C = 5'b11111;

  // True when the halfword is the first half of a 32-bit encoding.
  function automatic logic is_prefix32(input halfword_t hw);
    return (hw[15:11] == PREFIX32_A) ||
           (hw[15:11] == PREFIX32_B) ||
           (hw[15:11] == PREFIX32_C);
  endfunction

endpackage

// File: rtl/thumb_len_dec.sv
// Thumb instruction length decoder: flags a halfword that starts a 32-bit
// encoding. Purely combinational so pre-decode can share it.
module thumb_len_dec
  import thumb_fetch_queue_pkg::*;
(
  input  halfword_t hw,
  output logic      is32
);

  // Length class comes straight from the top five bits.
  always_comb begin
    is32 = is_prefix32(hw);
  end

endmodule

// File: rtl/thumb_fetch_queue.sv
// Thumb fetch queue: a circular halfword buffer fed by multi-lane fetch
// beats, presenting one assembled 16- or 32-bit instruction at its head.
module thumb_fetch_queue
  import thumb_fetch_queue_pkg::*;
#(
  parameter int FETCH_HW = 2,
  parameter int DEPTH    = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [16*FETCH_HW-1:0]       in_hw,
  input  logic [$clog2(FETCH_HW+1)-1:0] in_cnt,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         flush,
  output logic [31:0]                  inst,
  output logic                         inst_is32,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH+1);
  localparam int CW = $clog2(FETCH_HW+1);

  halfword_t         mem_reg [DEPTH];
  logic [PW-1:0]     rd_ptr_reg, rd_ptr_next;
  logic [PW-1:0]     wr_ptr_reg, wr_ptr_next;
  logic [OW-1:0]     occ_reg, occ_next;

  halfword_t         head_hw, head2_hw;
  logic              head_is32;
  logic              push, pop;
  logic [CW-1:0]     push_cnt;
  logic [1:0]        pop_cnt;

  halfword_t         lane_hw  [FETCH_HW];
  logic [PW-1:0]     lane_idx [FETCH_HW];
  logic              lane_we  [FETCH_HW];

  // Space check uses registered occupancy only; a same-cycle pop earns no credit.
  assign in_ready = (occ_reg <= OW'(DEPTH - FETCH_HW));

  assign head_hw  = mem_reg[rd_ptr_reg];
  assign head2_hw = mem_reg[rd_ptr_reg + PW'(1)];

  thumb_len_dec u_len_dec (
    .hw   (head_hw),
    .is32 (head_is32)
  );

  // A lone prefix waits for its second half; anything else needs one entry.
  assign out_valid = ((occ_reg >= OW'(1)) && !head_is32) || (occ_reg >= OW'(2));
  assign inst      = !out_valid ? 32'h0000_0000 :
                     head_is32  ? {head_hw, head2_hw} : {16'h0000, head_hw};
  assign inst_is32 = out_valid && head_is32;
  assign occupancy = occ_reg;

  assign push     = in_valid && in_ready && !flush;
  assign pop      = out_valid && out_ready && !flush;
  assign push_cnt = push ? in_cnt : '0;
  assign pop_cnt  = !pop ? 2'd0 : (head_is32 ? 2'd2 : 2'd1);

  // Per-lane write slot and enable; lanes above in_cnt stay idle.
  generate
    for (genvar gi = 0; gi < FETCH_HW; gi++) begin : g_lane
      assign lane_hw[gi]  = in_hw[gi*16 +: 16];
      assign lane_idx[gi] = wr_ptr_reg + PW'(gi);
      assign lane_we[gi]  = push && (CW'(gi) < in_cnt);
    end
  endgenerate

  // Pointer and occupancy update; flush clears everything, reset wins over all.
  always_comb begin
    rd_ptr_next = rd_ptr_reg + PW'(pop_cnt);
    wr_ptr_next = wr_ptr_reg + PW'(push_cnt);
    occ_next    = occ_reg + OW'(push_cnt) - OW'(pop_cnt);
    if (flush) begin
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      occ_next    = '0;
    end
  end

  // Registered queue control state.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      occ_reg    <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      occ_reg    <= occ_next;
    end
  end

  // Halfword storage: plain flops, contents need no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_HW; i++) begin
      if (lane_we[i]) begin
        mem_reg[lane_idx[i]] <= lane_hw[i];
      end
    end
  end

endmodule

// File: tb/tb_thumb_fetch_queue.sv
// Bench for thumb_fetch_queue: directed beats with a scoreboard of expected
// instructions, popped whenever decode accepts one.
module tb_thumb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in_hw = '0;
  logic [1:0]  in_cnt = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        flush = 1'b0;
  logic [31:0] inst;
  logic        inst_is32;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  occupancy;

  int checks_cnt = 0;
  int fail_cnt   = 0;
  logic [32:0] sb_q [$];

  thumb_fetch_queue #(.FETCH_HW(2), .DEPTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_hw     (in_hw),
    .in_cnt    (in_cnt),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .inst      (inst),
    .inst_is32 (inst_is32),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end else begin
      $display("ok   %s value=%h", tag, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] hw, input logic [1:0] cnt);
    in_hw    = hw;
    in_cnt   = cnt;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic sb_push(input logic [31:0] exp_inst, input logic exp_is32);
    sb_q.push_back({exp_is32, exp_inst});
  endtask

  task automatic wait_empty(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (occupancy == 4'd0) break;
      tick();
    end
    check_eq(tag, 32'(occupancy), 32'd0);
  endtask

  // Every accepted instruction is compared against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && !flush && out_valid && out_ready) begin
      check_eq("sb_avail", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        logic [32:0] e;
        e = sb_q.pop_front();
        check_eq("sb_inst", inst, e[31:0]);
        check_eq("sb_is32", 32'(inst_is32), 32'(e[32]));
      end
    end
  end

  initial begin
    // Reset state
    tick();
    tick();
    rst = 1'b0;
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_inst", inst, 32'd0);
    check_eq("rst_is32", 32'(inst_is32), 32'd0);
    check_eq("rst_occ", 32'(occupancy), 32'd0);
    check_eq("rst_ready", 32'(in_ready), 32'd1);

    // Two 16-bit instructions in one beat, consumed back to back
    out_ready = 1'b1;
    sb_push(32'h0000_4608, 1'b0);
    sb_push(32'h0000_BF00, 1'b0);
    beat({16'hBF00, 16'h4608}, 2'd2);
    check_eq("t1_occ2", 32'(occupancy), 32'd2);
    tick();
    check_eq("t1_occ1", 32'(occupancy), 32'd1);
    tick();
    check_eq("t1_occ0", 32'(occupancy), 32'd0);
    check_eq("t1_idle", 32'(out_valid), 32'd0);

    // Lone prefix waits for its second half
    beat({16'hF000, 16'hE92D}, 2'd1);
    check_eq("t2_wait_valid", 32'(out_valid), 32'd0);
    check_eq("t2_wait_occ", 32'(occupancy), 32'd1);
    tick();
    check_eq("t2_hold_valid", 32'(out_valid), 32'd0);
    sb_push(32'hE92D_F000, 1'b1);
    beat({16'h0000, 16'hF000}, 2'd1);
    check_eq("t2_inst", inst, 32'hE92D_F000);
    check_eq("t2_is32", 32'(inst_is32), 32'd1);
    tick();
    check_eq("t2_occ0", 32'(occupancy), 32'd0);

    // Fill to 7, back-pressure, then one pop frees a beat's worth of space
    out_ready = 1'b0;
    for (int b = 0; b < 3; b++) begin
      sb_push({16'h0, 16'h1000 + 16'(2*b)}, 1'b0);
      sb_push({16'h0, 16'h1001 + 16'(2*b)}, 1'b0);
      beat({16'h1001 + 16'(2*b), 16'h1000 + 16'(2*b)}, 2'd2);
    end
    sb_push(32'h0000_1006, 1'b0);
    beat({16'h0000, 16'h1006}, 2'd1);
    check_eq("t3_occ7", 32'(occupancy), 32'd7);
    check_eq("t3_full_ready", 32'(in_ready), 32'd0);
    beat({16'h2222, 16'h2222}, 2'd2);
    check_eq("t3_not_accepted", 32'(occupancy), 32'd7);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("t3_occ6", 32'(occupancy), 32'd6);
    check_eq("t3_ready_again", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    wait_empty("t3_drain");

    // 32-bit instruction straddling the wrap: halves at index 7 and 0
    for (int b = 0; b < 2; b++) begin
      sb_push({16'h0, 16'h3000 + 16'(2*b)}, 1'b0);
      sb_push({16'h0, 16'h3001 + 16'(2*b)}, 1'b0);
      beat({16'h3001 + 16'(2*b), 16'h3000 + 16'(2*b)}, 2'd2);
    end
    wait_empty("t4_drain");
    out_ready = 1'b0;
    sb_push(32'hF7FF_FFFE, 1'b1);
    beat({16'hFFFE, 16'hF7FF}, 2'd2);
    check_eq("t4_rd_at7", 32'(dut.rd_ptr_reg), 32'd7);
    check_eq("t4_inst", inst, 32'hF7FF_FFFE);
    check_eq("t4_is32", 32'(inst_is32), 32'd1);
    out_ready = 1'b1;
    tick();
    check_eq("t4_rd_wrap", 32'(dut.rd_ptr_reg), 32'd1);
    check_eq("t4_occ0", 32'(occupancy), 32'd0);

    // Flush with a beat and a pop in the same cycle at occupancy 5
    out_ready = 1'b0;
    beat({16'h4001, 16'h4000}, 2'd2);
    beat({16'h4003, 16'h4002}, 2'd2);
    beat({16'h0000, 16'h4004}, 2'd1);
    check_eq("t5_occ5", 32'(occupancy), 32'd5);
    in_hw     = {16'h5555, 16'h5555};
    in_cnt    = 2'd2;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    flush     = 1'b1;
    tick();
    flush     = 1'b0;
    in_valid  = 1'b0;
    check_eq("t5_occ0", 32'(occupancy), 32'd0);
    check_eq("t5_valid", 32'(out_valid), 32'd0);
    check_eq("t5_rd0", 32'(dut.rd_ptr_reg), 32'd0);
    check_eq("t5_wr0", 32'(dut.wr_ptr_reg), 32'd0);
    tick();
    check_eq("t5_dropped", 32'(occupancy), 32'd0);
    sb_push(32'hE800_1234, 1'b1);
    beat({16'h1234, 16'hE800}, 2'd2);
    wait_empty("t5_drain");

    // Reset in the middle of a 32-bit assembly
    beat({16'h0000, 16'hF000}, 2'd1);
    check_eq("t6_wait_valid", 32'(out_valid), 32'd0);
    check_eq("t6_wait_occ", 32'(occupancy), 32'd1);
    rst      = 1'b1;
    in_hw    = {16'h0000, 16'h8000};
    in_cnt   = 2'd1;
    in_valid = 1'b1;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    check_eq("t6_valid", 32'(out_valid), 32'd0);
    check_eq("t6_inst", inst, 32'd0);
    check_eq("t6_is32", 32'(inst_is32), 32'd0);
    check_eq("t6_occ", 32'(occupancy), 32'd0);
    check_eq("t6_ready", 32'(in_ready), 32'd1);
    check_eq("t6_rd0", 32'(dut.rd_ptr_reg), 32'd0);
    sb_push(32'h0000_BF00, 1'b0);
    beat({16'h0000, 16'hBF00}, 2'd1);
    wait_empty("t6_drain");
    tick();

    check_eq("sb_left", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule
